// File: rtl/uart_tx_ctrl_pkg.sv
// uart_tx_ctrl_pkg: register addresses and STATUS/CTRL bit positions for the UART transmit controller
package uart_tx_ctrl_pkg;
    localparam logic [29:0] DATA_WADDR = 30'h2c000000;
    localparam logic [29:0] CTRL_WADDR = 30'h2c000001;
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_OVF       = 8;
    localparam int ST_IRQEN     = 9;
    localparam int CT_IRQEN     = 0;
    localparam int CT_CLROVF    = 1;
    localparam int CT_FLUSH     = 2;
endpackage

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// sync_fifo: power-of-two byte FIFO with push-when-full-and-popping and flush priority
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty & ~flush;
    // a full FIFO still accepts when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop) & ~flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped transmit FIFO feeding a UART serializer, with STATUS/CTRL and TX-empty irq
module uart_tx_ctrl #(
    parameter int          DEPTH      = 8,
    parameter int          AW         = 3,
    parameter logic [29:0] DATA_WADDR = uart_tx_ctrl_pkg::DATA_WADDR,
    parameter logic [29:0] CTRL_WADDR = uart_tx_ctrl_pkg::CTRL_WADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    import uart_tx_ctrl_pkg::*;

    logic          we_d, irq_en, overflow;
    logic          wr_evt, data_evt, ctrl_evt, flush, pop, full, empty, nxt_zero;
    logic [AW:0]   count;
    logic [31:0]   status;

    // one event per store, however long we stays high
    assign wr_evt   = we & ~we_d;
    assign data_evt = wr_evt & (addr == DATA_WADDR);
    assign ctrl_evt = wr_evt & (addr == CTRL_WADDR);
    assign flush    = ctrl_evt & wdata[CT_FLUSH];
    assign tx_valid = ~empty;
    assign pop      = tx_valid & tx_ready;
    assign nxt_zero = flush | (empty & ~data_evt) | (count == (AW+1)'(1) & pop & ~data_evt);

    sync_fifo #(.DEPTH(DEPTH), .AW(AW), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_evt),
        .pop   (pop),
        .flush (flush),
        .din   (wdata[7:0]),
        .dout  (tx_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_d     <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            we_d     <= we;
            irq_en   <= ctrl_evt ? wdata[CT_IRQEN] : irq_en;
            overflow <= (ctrl_evt & wdata[CT_CLROVF]) ? 1'b0 : (data_evt & full & ~tx_ready) ? 1'b1 : overflow;
            irq      <= irq_en & nxt_zero;
        end
    end

    always_comb begin
        status                       = '0;
        status[ST_FULL]              = full;
        status[ST_EMPTY]             = empty;
        status[ST_COUNT_LSB +: 4]    = 4'(count);
        status[ST_OVF]               = overflow;
        status[ST_IRQEN]             = irq_en;
        rdata                        = (addr == CTRL_WADDR) ? status : '0;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Memory-mapped transmit controller between the CPU store path and the UART byte serializer.
- Detects CPU writes to the UART DATA word and buffers the bytes in a small FIFO.
- Hands bytes to the serializer over a valid/ready handshake.
- Exposes a STATUS/CTRL word with fill level, sticky overflow, flush and a TX-empty interrupt.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of two, minimum 2.
- AW, 3: log2(DEPTH).
- DATA_WADDR, 30'h2c000000: word address of the DATA register.
- CTRL_WADDR, 30'h2c000001: word address of the STATUS/CTRL register.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- we  in  1  CPU write enable; may stay high for several cycles per store.
- addr  in  30  CPU word address [31:2].
- wdata  in  32  CPU write data.
- rdata  out  32  read data for the current addr (combinational).
- tx_data  out  8  byte at the FIFO head.
- tx_valid  out  1  FIFO is non-empty.
- tx_ready  in  1  serializer accepts a byte.
- irq  out  1  transmit-empty interrupt (registered).

Behaviour:
- Reset (rst=0, asynchronous): clears rd_ptr, wr_ptr, count, we_d, irq_en, overflow and irq to 0. tx_valid is 0. FIFO memory is not reset.
- Write strobe: we_d is a registered copy of we. wr_evt = we & ~we_d, so one store causes exactly one event however long we is held. The event applies in the cycle where we first rises.
- DATA write (wr_evt, addr==DATA_WADDR): push wdata[7:0].
  - Push allowed if count<DEPTH, or if count==DEPTH and a pop happens in the same cycle. In that case the push is accepted and count stays unchanged.
  - Otherwise the byte is dropped and overflow is set; overflow is sticky.
- CTRL write (wr_evt, addr==CTRL_WADDR):
  - bit0 sets irq_en.
  - bit1=1 clears overflow.
  - bit2=1 flushes: pointers and count go to 0 on the next edge.
- Pop: when tx_valid & tx_ready, rd_ptr increments.
  - tx_valid = (count!=0). tx_data = mem[rd_ptr].
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
- Latency: a push into an empty FIFO raises tx_valid in the next cycle. There is no combinational path from we to tx_valid.
- Pointers are AW bits wide and wrap modulo DEPTH. count is AW+1 bits: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous events:
  - Flush has priority over push and pop in the same cycle. The push is dropped without setting overflow; the pop is discarded.
  - A CTRL write that both clears overflow and flushes does both.
  - Overflow set and clear cannot coincide, because only one address is active per event.
- rdata:
  - addr==CTRL_WADDR: {22'b0, irq_en[9], overflow[8], count[7:4] zero-extended, 2'b0, empty[1], full[0]}.
  - addr==DATA_WADDR: 0.
  - Any other addr: 0.
- irq is registered: irq <= irq_en & (next count==0). It deasserts the cycle after a push makes the FIFO non-empty.
- Reset mid-transfer: tx_valid drops immediately (asynchronously). Any byte the serializer latched before reset is the serializer's responsibility.

Decomposition:
- Shared package holds:
  - the address constants DATA_WADDR and CTRL_WADDR;
  - STATUS bit positions (ST_FULL=0, ST_EMPTY=1, ST_COUNT_LSB=4, ST_OVF=8, ST_IRQEN=9);
  - CTRL bit positions (CT_IRQEN=0, CT_CLROVF=1, CT_FLUSH=2).
- One sub-module, sync_fifo (params DEPTH, AW, WIDTH=8):
  - ports: push, pop, flush, din, dout, count, full, empty;
  - implements the pointer, count, wrap and flush-priority rules above.
- uart_tx_ctrl contains edge detect, address decode, overflow and irq_en registers, rdata mux and irq.

Test Plan:
- Reset then single store: write DATA=0x41, we held 3 cycles, tx_ready=0.
  - Expect exactly one push.
  - tx_valid=1 and tx_data=0x41 one cycle after the event.
  - STATUS count=1, empty=0.
- Fill and overflow: 9 distinct stores 0x00..0x08 with tx_ready=0.
  - Expect full=1, count=8, overflow=1.
  - Draining with tx_ready=1 yields 0x00..0x07 in order; 0x08 is lost.
  - CTRL write 0x2 then clears overflow.
- Full with push and pop together: count=8, store 0x55 in the same cycle as a tx handshake.
  - count stays 8, no overflow.
  - 0x55 emerges last after the wrap of wr_ptr.
- Backpressure: 3 bytes queued, tx_ready toggled 1,0,0,1,1.
  - tx_data stable during stalls.
  - Bytes delivered in order, exactly 3 handshakes.
- Flush priority: count=5, CTRL write 0x4 with a coincident pop.
  - Next cycle count=0, tx_valid=0, overflow unchanged.
  - A following DATA store is delivered normally.
- irq and async reset:
  - irq_en=1, send 2 bytes, drain: irq rises the cycle after count reaches 0 and falls the cycle after the next store.
  - Pulling rst=0 mid-edge clears tx_valid and irq without waiting for a clock edge.
